// File: rtl/zoom_pkg.sv
// Shared types and sizing helpers for the zoom sequencer.
package zoom_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAPTURE = 2'd1,
        REMAP   = 2'd2
    } zoom_state_t;

    // Bits needed to index n items, never less than one.
    function automatic int unsigned bits_for(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    function automatic int unsigned addr_w(input int unsigned w, input int unsigned h);
        return bits_for(w * h);
    endfunction

endpackage

// File: rtl/zoom_remap.sv
// Combinational destination-to-source coordinate mapper: each half of the
// frame is pulled toward its own edge by z pixels, clamped at the centre line.
module zoom_remap
    import zoom_pkg::*;
#(
    parameter int unsigned IMG_WIDTH  = 640,
    parameter int unsigned IMG_HEIGHT = 480,
    parameter int unsigned MID_X      = 319,
    parameter int unsigned MID_Y      = 239,
    parameter int unsigned ZOOM_MAX   = 32
) (
    input  logic [bits_for(IMG_WIDTH)-1:0]  dx,
    input  logic [bits_for(IMG_HEIGHT)-1:0] dy,
    input  logic [bits_for(ZOOM_MAX+1)-1:0] z,
    output logic [bits_for(IMG_WIDTH)-1:0]  sx_c,
    output logic [bits_for(IMG_HEIGHT)-1:0] sy_c
);

    localparam int unsigned XW = bits_for(IMG_WIDTH);
    localparam int unsigned YW = bits_for(IMG_HEIGHT);

    logic [31:0] dx_w;
    logic [31:0] dy_w;
    logic [31:0] z_w;

    // Wide arithmetic so dx+z cannot wrap and dx-z cannot underflow.
    always_comb begin
        dx_w = 32'(dx);
        dy_w = 32'(dy);
        z_w  = 32'(z);

        if (dx_w <= 32'(MID_X)) begin
            sx_c = (dx_w + z_w >= 32'(MID_X)) ? XW'(MID_X) : XW'(dx_w + z_w);
        end else begin
            sx_c = (dx_w >= 32'(MID_X) + 32'd1 + z_w) ? XW'(dx_w - z_w) : XW'(MID_X + 1);
        end

        if (dy_w <= 32'(MID_Y)) begin
            sy_c = (dy_w + z_w >= 32'(MID_Y)) ? YW'(MID_Y) : YW'(dy_w + z_w);
        end else begin
            sy_c = (dy_w >= 32'(MID_Y) + 32'd1 + z_w) ? YW'(dy_w - z_w) : YW'(MID_Y + 1);
        end
    end

endmodule

// File: rtl/zoom_sequencer.sv
// Captures one frame into an external buffer, then reads it back in raster
// order through the zoom remapper at the zoom level latched for that frame.
module zoom_sequencer
    import zoom_pkg::*;
#(
    parameter int unsigned IMG_WIDTH  = 640,
    parameter int unsigned IMG_HEIGHT = 480,
    parameter int unsigned MID_X      = 319,
    parameter int unsigned MID_Y      = 239,
    parameter int unsigned ZOOM_MAX   = 32,
    parameter int unsigned ZOOM_STEP  = 4
) (
    input  logic                                        clk,
    input  logic                                        reset,
    input  logic                                        pixel_in_valid,
    output logic                                        in_ready,
    input  logic                                        zoom_up,
    input  logic                                        zoom_down,
    input  logic                                        out_ready,
    output logic                                        wr_en,
    output logic [addr_w(IMG_WIDTH, IMG_HEIGHT)-1:0]    wr_addr,
    output logic                                        rd_en,
    output logic [addr_w(IMG_WIDTH, IMG_HEIGHT)-1:0]    rd_addr,
    output logic                                        out_valid,
    output logic [bits_for(ZOOM_MAX+1)-1:0]             zoom_level,
    output logic                                        busy,
    output logic                                        frame_done
);

    localparam int unsigned ADDR_W = addr_w(IMG_WIDTH, IMG_HEIGHT);
    localparam int unsigned XW     = bits_for(IMG_WIDTH);
    localparam int unsigned YW     = bits_for(IMG_HEIGHT);
    localparam int unsigned ZW     = bits_for(ZOOM_MAX + 1);
    localparam int unsigned N      = IMG_WIDTH * IMG_HEIGHT;
    localparam logic [31:0] W_BITS = 32'(IMG_WIDTH);

    zoom_state_t       state;
    zoom_state_t       state_d;
    logic [ADDR_W-1:0] wr_cnt;
    logic [ADDR_W-1:0] wr_cnt_d;
    logic [XW-1:0]     dx;
    logic [XW-1:0]     dx_d;
    logic [YW-1:0]     dy;
    logic [YW-1:0]     dy_d;
    logic [ZW-1:0]     zoom_pending;
    logic [ZW-1:0]     zoom_pending_d;
    logic [ZW-1:0]     zoom_level_d;
    logic              rd_last;
    logic              rd_last_d;
    logic              in_ready_d;
    logic              wr_en_d;
    logic [ADDR_W-1:0] wr_addr_d;
    logic              rd_en_d;
    logic [ADDR_W-1:0] rd_addr_d;
    logic              out_valid_d;
    logic              busy_d;
    logic              frame_done_d;
    logic [31:0]       zoom_sum;

    logic [XW-1:0]     sx;
    logic [YW-1:0]     sy;
    logic [ADDR_W-1:0] row_base;

    zoom_remap #(
        .IMG_WIDTH  (IMG_WIDTH),
        .IMG_HEIGHT (IMG_HEIGHT),
        .MID_X      (MID_X),
        .MID_Y      (MID_Y),
        .ZOOM_MAX   (ZOOM_MAX)
    ) u_remap (
        .dx   (dx),
        .dy   (dy),
        .z    (zoom_level),
        .sx_c (sx),
        .sy_c (sy)
    );

    // sy * IMG_WIDTH as a sum of constant shifts, one term per set width bit.
    always_comb begin
        row_base = '0;
        for (int i = 0; i < 32; i++) begin
            if (W_BITS[i]) begin
                row_base = row_base + (ADDR_W'(sy) << i);
            end
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_d        = state;
        wr_cnt_d       = wr_cnt;
        dx_d           = dx;
        dy_d           = dy;
        zoom_pending_d = zoom_pending;
        zoom_level_d   = zoom_level;
        rd_last_d      = 1'b0;
        wr_en_d        = 1'b0;
        wr_addr_d      = wr_addr;
        rd_en_d        = 1'b0;
        rd_addr_d      = rd_addr;
        out_valid_d    = rd_en;
        frame_done_d   = rd_en & rd_last;
        zoom_sum       = 32'(zoom_pending) + 32'(ZOOM_STEP);

        case ({zoom_up, zoom_down})
            2'b10: zoom_pending_d = (zoom_sum >= 32'(ZOOM_MAX)) ? ZW'(ZOOM_MAX) : ZW'(zoom_sum);
            2'b01: zoom_pending_d = (32'(zoom_pending) <= 32'(ZOOM_STEP)) ? '0
                                    : zoom_pending - ZW'(ZOOM_STEP);
            default: ;
        endcase

        case (state)
            IDLE, CAPTURE: begin
                // wr_cnt is zero in IDLE, so the first pixel lands at address 0.
                if (pixel_in_valid) begin
                    wr_en_d   = 1'b1;
                    wr_addr_d = wr_cnt;
                    if (wr_cnt == ADDR_W'(N - 1)) begin
                        wr_cnt_d     = '0;
                        dx_d         = '0;
                        dy_d         = '0;
                        zoom_level_d = zoom_pending;
                        state_d      = REMAP;
                    end else begin
                        wr_cnt_d = wr_cnt + 1'b1;
                        state_d  = CAPTURE;
                    end
                end
            end
            REMAP: begin
                if (out_ready) begin
                    rd_en_d   = 1'b1;
                    rd_addr_d = row_base + ADDR_W'(sx);
                    if (dx == XW'(IMG_WIDTH - 1)) begin
                        dx_d = '0;
                        if (dy == YW'(IMG_HEIGHT - 1)) begin
                            dy_d      = '0;
                            rd_last_d = 1'b1;
                            state_d   = IDLE;
                        end else begin
                            dy_d = dy + 1'b1;
                        end
                    end else begin
                        dx_d = dx + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        in_ready_d = (state_d != REMAP);
        busy_d     = (state_d != IDLE) | rd_en_d | rd_en;
    end

    // State and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            wr_cnt       <= '0;
            dx           <= '0;
            dy           <= '0;
            zoom_pending <= '0;
            zoom_level   <= '0;
            rd_last      <= 1'b0;
            in_ready     <= 1'b1;
            wr_en        <= 1'b0;
            wr_addr      <= '0;
            rd_en        <= 1'b0;
            rd_addr      <= '0;
            out_valid    <= 1'b0;
            busy         <= 1'b0;
            frame_done   <= 1'b0;
        end else begin
            state        <= state_d;
            wr_cnt       <= wr_cnt_d;
            dx           <= dx_d;
            dy           <= dy_d;
            zoom_pending <= zoom_pending_d;
            zoom_level   <= zoom_level_d;
            rd_last      <= rd_last_d;
            in_ready     <= in_ready_d;
            wr_en        <= wr_en_d;
            wr_addr      <= wr_addr_d;
            rd_en        <= rd_en_d;
            rd_addr      <= rd_addr_d;
            out_valid    <= out_valid_d;
            busy         <= busy_d;
            frame_done   <= frame_done_d;
        end
    end

endmodule

// File: tb/tb_zoom_sequencer.sv
// Directed bench for zoom_sequencer on an 8x6 frame with hand-computed addresses.
module tb_zoom_sequencer;

    localparam int unsigned W  = 8;
    localparam int unsigned H  = 6;
    localparam int unsigned NP = W * H;

    logic       clk = 1'b0;
    logic       reset;
    logic       pixel_in_valid;
    logic       in_ready;
    logic       zoom_up;
    logic       zoom_down;
    logic       out_ready;
    logic       wr_en;
    logic [5:0] wr_addr;
    logic       rd_en;
    logic [5:0] rd_addr;
    logic       out_valid;
    logic [2:0] zoom_level;
    logic       busy;
    logic       frame_done;

    int total = 0;
    int bad   = 0;

    int rd_log [0:127];
    int rd_n, ov_n, fd_n, fd_ov;
    bit overlap, stall_err, timeout;

    zoom_sequencer #(
        .IMG_WIDTH (W), .IMG_HEIGHT (H), .MID_X (3), .MID_Y (2),
        .ZOOM_MAX (4), .ZOOM_STEP (2)
    ) dut (
        .clk (clk), .reset (reset), .pixel_in_valid (pixel_in_valid),
        .in_ready (in_ready), .zoom_up (zoom_up), .zoom_down (zoom_down),
        .out_ready (out_ready), .wr_en (wr_en), .wr_addr (wr_addr),
        .rd_en (rd_en), .rd_addr (rd_addr), .out_valid (out_valid),
        .zoom_level (zoom_level), .busy (busy), .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_frame();
        out_ready = 1'b0;
        for (int i = 0; i < int'(NP); i++) begin
            pixel_in_valid = 1'b1;
            step();
        end
        pixel_in_valid = 1'b0;
    endtask

    // Drives out_ready (mode 1 stalls three cycles mid-row) and logs the read side.
    task automatic run_remap(input int mode);
        rd_n = 0; ov_n = 0; fd_n = 0; fd_ov = -1;
        overlap = 0; stall_err = 0; timeout = 1;
        for (int c = 0; c < 200; c++) begin
            out_ready = !(mode == 1 && c >= 10 && c < 13);
            step();
            if (rd_en && wr_en) overlap = 1;
            if (mode == 1 && c >= 10 && c < 13 && rd_en) stall_err = 1;
            if (rd_en) begin
                if (rd_n < 128) rd_log[rd_n] = int'(rd_addr);
                rd_n++;
            end
            if (out_valid) ov_n++;
            if (frame_done) begin
                fd_n++;
                fd_ov = ov_n;
                timeout = 0;
                break;
            end
        end
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step();
        total++;
        if ({in_ready, wr_en, rd_en, out_valid, busy, frame_done} !== 6'b100000) begin
            bad++;
            $display("FAIL reset_strobes got=%b want=100000",
                     {in_ready, wr_en, rd_en, out_valid, busy, frame_done});
        end
        total++;
        if ({wr_addr, rd_addr, zoom_level} !== 15'd0) begin
            bad++;
            $display("FAIL reset_values wr=%0d rd=%0d zl=%0d want 0", wr_addr, rd_addr, zoom_level);
        end
        reset = 1'b0;
    endtask

    task automatic test_capture();
        out_ready = 1'b0;
        for (int i = 0; i < int'(NP); i++) begin
            pixel_in_valid = 1'b1;
            step();
            total++;
            if (wr_en !== 1'b1 || wr_addr !== 6'(i)) begin
                bad++;
                $display("FAIL capture_write[%0d] wr_en=%b wr_addr=%0d want 1/%0d", i, wr_en, wr_addr, i);
            end
        end
        total++;
        if (in_ready !== 1'b0 || busy !== 1'b1) begin
            bad++;
            $display("FAIL capture_enter_remap in_ready=%b busy=%b want 0/1", in_ready, busy);
        end
        // Still offering pixels while in REMAP must not write anything.
        step();
        pixel_in_valid = 1'b0;
        total++;
        if (wr_en !== 1'b0 || rd_en !== 1'b0) begin
            bad++;
            $display("FAIL remap_ignores_input wr_en=%b rd_en=%b want 0/0", wr_en, rd_en);
        end
    endtask

    task automatic check_linear(input string tag);
        total++;
        if (timeout || rd_n !== int'(NP) || ov_n !== int'(NP)) begin
            bad++;
            $display("FAIL %s_counts timeout=%0d reads=%0d valids=%0d want 0/48/48", tag, timeout, rd_n, ov_n);
        end
        for (int i = 0; i < int'(NP) && i < rd_n; i++) begin
            total++;
            if (rd_log[i] !== i) begin
                bad++;
                $display("FAIL %s_addr[%0d] got=%0d want=%0d", tag, i, rd_log[i], i);
            end
        end
        total++;
        if (fd_n !== 1 || fd_ov !== int'(NP) || overlap) begin
            bad++;
            $display("FAIL %s_done fd=%0d at_valid=%0d overlap=%0d want 1/48/0", tag, fd_n, fd_ov, overlap);
        end
    endtask

    task automatic test_linear();
        run_remap(0);
        check_linear("linear");
        step();
        total++;
        if (busy !== 1'b0 || in_ready !== 1'b1 || frame_done !== 1'b0) begin
            bad++;
            $display("FAIL linear_idle busy=%b in_ready=%b fd=%b want 0/1/0", busy, in_ready, frame_done);
        end
    endtask

    task automatic test_zoom();
        zoom_up = 1'b1;
        step();
        zoom_up = 1'b0;
        send_frame();
        total++;
        if (zoom_level !== 3'd2) begin
            bad++;
            $display("FAIL zoom_latch got=%0d want=2", zoom_level);
        end
        run_remap(0);
        total++;
        if (timeout || rd_n !== int'(NP)) begin
            bad++;
            $display("FAIL zoom_reads timeout=%0d reads=%0d want 0/48", timeout, rd_n);
        end
        total++;
        if (rd_log[0] !== 18 || rd_log[3] !== 19) begin
            bad++;
            $display("FAIL zoom_row0 got=%0d,%0d want=18,19", rd_log[0], rd_log[3]);
        end
        total++;
        if (rd_log[28] !== 28 || rd_log[47] !== 29) begin
            bad++;
            $display("FAIL zoom_lower got=%0d,%0d want=28,29", rd_log[28], rd_log[47]);
        end
    endtask

    task automatic test_stall();
        zoom_down = 1'b1;
        step();
        zoom_down = 1'b0;
        send_frame();
        run_remap(1);
        check_linear("stall");
        total++;
        if (stall_err) begin
            bad++;
            $display("FAIL stall_rd_en got=1 want=0 during out_ready low");
        end
    endtask

    task automatic test_saturate();
        for (int i = 0; i < 3; i++) begin
            zoom_up = 1'b1;
            step();
            zoom_up = 1'b0;
            step();
        end
        send_frame();
        total++;
        if (zoom_level !== 3'd4) begin
            bad++;
            $display("FAIL zoom_saturate got=%0d want=4", zoom_level);
        end
        // A request during REMAP must not disturb the frame in flight.
        zoom_down = 1'b1;
        step();
        zoom_down = 1'b0;
        run_remap(0);
        total++;
        if (zoom_level !== 3'd4 || rd_log[0] !== 19 || rd_log[47] !== 28) begin
            bad++;
            $display("FAIL zoom_hold zl=%0d first=%0d last=%0d want 4/19/28", zoom_level, rd_log[0], rd_log[47]);
        end
        zoom_up = 1'b1;
        zoom_down = 1'b1;
        step();
        zoom_up = 1'b0;
        zoom_down = 1'b0;
        send_frame();
        total++;
        if (zoom_level !== 3'd2) begin
            bad++;
            $display("FAIL zoom_both got=%0d want=2", zoom_level);
        end
        run_remap(0);
        total++;
        if (timeout || rd_log[0] !== 18) begin
            bad++;
            $display("FAIL zoom_next_frame timeout=%0d first=%0d want 0/18", timeout, rd_log[0]);
        end
    endtask

    task automatic test_reset_mid();
        send_frame();
        out_ready = 1'b1;
        for (int c = 0; c < 19; c++) step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        out_ready = 1'b0;
        total++;
        if ({in_ready, wr_en, rd_en, out_valid, busy, frame_done} !== 6'b100000 || zoom_level !== 3'd0) begin
            bad++;
            $display("FAIL reset_mid strobes=%b zl=%0d want 100000/0",
                     {in_ready, wr_en, rd_en, out_valid, busy, frame_done}, zoom_level);
        end
        send_frame();
        run_remap(0);
        check_linear("after_reset");
    endtask

    initial begin
        reset = 1'b1;
        pixel_in_valid = 1'b0;
        zoom_up = 1'b0;
        zoom_down = 1'b0;
        out_ready = 1'b0;
        step();
        test_reset();
        test_capture();
        test_linear();
        test_zoom();
        test_stall();
        test_saturate();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
